dac_code_sequencer: RTL and testbench
=====================================

// Module: dac_code_sequencer
//
// PURPOSE
//  Slew-limited sequencer for the 4-bit segmented DAC code path. Buffers target
//  codes from the host in a small FIFO and walks the registered code one LSB at
//  a time toward each target, at a programmable step rate. After each target is
//  reached it waits a fixed settle time and then pulses done. code_out drives the
//  binary-to-thermometer decoder directly, so only one thermometer segment
//  toggles per step.
//
// PARAMETERS
//  CODE_W      4      width of DAC code
//  DEPTH       4      target FIFO depth; power of 2, >= 2
//  DIV_W       8      width of step_div
//  SETTLE_CYC  2      settle wait after target reached, cycles (0 legal)
//  RESET_CODE  4'hF   code_out after reset (= decoder all-zero thermometer)
//
// PORTS
//  clk        in   1       clock, rising edge
//  resetb     in   1       synchronous reset, active low
//  in_valid   in   1       target code valid
//  in_ready   out  1       FIFO can accept (registered, = !full)
//  in_code    in   CODE_W  target code
//  enable     in   1       1 = sequencer runs; 0 = freeze state/counters
//  flush      in   1       sync clear of FIFO + return to IDLE, code held
//  step_div   in   DIV_W   cycles between steps minus 1 (0 = step every cycle)
//  code_out   out  CODE_W  registered code to decoder
//  busy       out  1       state != IDLE
//  done       out  1       1-cycle pulse: target reached and settled
//  fifo_cnt   out  log2(DEPTH)+1  entries in FIFO
//
// BEHAVIOUR
//  Reset
//   - resetb=0 at edge: code_out=RESET_CODE, FIFO empty, in_ready=1, state IDLE,
//     busy=0, done=0, counters 0. Overrides all, including mid-ramp.
//  FIFO
//   - Push on in_valid&&in_ready. in_ready is registered: 0 when full even if a
//     pop occurs the same cycle.
//   - Same-cycle push+pop: count unchanged.
//   - flush=1: FIFO empty next cycle; a same-cycle push is dropped.
//  FSM
//   - IDLE: if enable && !empty && !flush, pop head into target, cnt<=step_div.
//     Go to RAMP if head != code_out, else go straight to SETTLE.
//   - RAMP: each enabled cycle, if cnt!=0 then cnt<=cnt-1. Else code_out +/-1
//     toward target (no wrap; unsigned compare) and cnt<=step_div. If the new
//     code equals target, go to SETTLE with scnt<=SETTLE_CYC.
//   - SETTLE: if scnt!=0 then scnt<=scnt-1. Else done<=1 and go to IDLE.
//   - enable=0: state, cnt, scnt and code_out hold; no pop; FIFO still pushes.
//   - flush in RAMP/SETTLE: go to IDLE next edge, code_out holds, no done.
//   - step_div is sampled on every counter reload; mid-ramp changes apply at
//     the next reload.
//  Timing
//   - First step occurs step_div+1 cycles after the pop edge.
//   - A ramp of N LSBs takes N*(step_div+1) cycles from pop to the last step.
//   - done rises SETTLE_CYC+1 cycles after the last step.
//   - A back-to-back pop can occur in the cycle after done.
//  Invariants
//   - code_out changes by at most 1 LSB per cycle.
//   - code_out never leaves the range [min(start,target), max(start,target)].
//
// TESTING
//  T1 reset: resetb=0 mid-ramp -> next edge code_out=F, busy=0, fifo_cnt=0,
//     in_ready=1.
//  T2 full ramp: step_div=0, push 0 -> code_out F,E,...,0 on 15 consecutive
//     edges, done 3 cycles after the last step.
//  T3 divider: step_div=3, code 5, push 7 -> 6 at pop+4, 7 at pop+8, one done.
//  T4 equal target: code_out=9, push 9 -> no code change, done at pop+3.
//  T5 FIFO: enable=0, push 4 codes -> in_ready=0, 5th push dropped; enable=1
//     -> targets run in order with 4 done pulses.
//  T6 flush/freeze: enable=0 mid-ramp holds code 2 cycles; then flush -> IDLE,
//     fifo_cnt=0, code held, no done.

Source files
------------

// File: rtl/dac_code_sequencer_if.sv
// Host-side bus of the DAC code sequencer.
//   master : host (drives targets, enable, flush, step rate; observes status)
//   slave  : sequencer
// Signals:
//   in_valid/in_ready/in_code : target-code push handshake
//   enable                    : run (1) / freeze (0)
//   flush                     : clear FIFO and abort the current target
//   step_div                  : cycles between LSB steps minus 1
//   code_out                  : registered code to the thermometer decoder
//   busy/done/fifo_cnt        : status
interface dac_code_sequencer_if #(
    parameter int CODE_W = 4,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              enable;
    logic              flush;
    logic [DIV_W-1:0]  step_div;
    logic [CODE_W-1:0] code_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  fifo_cnt;

    modport master (
        output in_valid, in_code, enable, flush, step_div,
        input  in_ready, code_out, busy, done, fifo_cnt
    );

    modport slave (
        input  in_valid, in_code, enable, flush, step_div,
        output in_ready, code_out, busy, done, fifo_cnt
    );
endinterface

// File: rtl/dac_code_sequencer.sv
// Slew-limited DAC code sequencer. Target codes are buffered in a small FIFO;
// the registered output code walks one LSB at a time toward each target at a
// rate of one step per (step_div+1) enabled cycles, waits SETTLE_CYC cycles
// after arriving, then pulses done for one cycle.
// Ports:
//   clk     : clock, rising edge
//   resetb  : synchronous reset, active low
//   bus     : dac_code_sequencer_if.slave (push handshake, control, status)
module dac_code_sequencer #(
    parameter int                CODE_W     = 4,
    parameter int                DEPTH      = 4,
    parameter int                DIV_W      = 8,
    parameter int                SETTLE_CYC = 2,
    parameter logic [CODE_W-1:0] RESET_CODE = 4'hF
) (
    input  logic                  clk,
    input  logic                  resetb,
    dac_code_sequencer_if.slave   bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SCNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_SETTLE
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   target_q, target_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CODE_W-1:0]   mem_q [DEPTH];

    logic                push;
    logic                pop;
    logic [CODE_W-1:0]   head;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        scnt_d     = scnt_q;
        done_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pop        = 1'b0;
        head       = mem_q[rd_ptr_q];
        // in_ready_q already reflects !full, so a full FIFO refuses a push
        // even when a pop happens in the same cycle.
        push       = bus.in_valid && in_ready_q && !bus.flush;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable && (count_q != '0) && !bus.flush) begin
                    pop      = 1'b1;
                    target_d = head;
                    cnt_d    = bus.step_div;
                    if (head != code_q) begin
                        state_d = ST_RAMP;
                    end else begin
                        state_d = ST_SETTLE;
                        scnt_d  = SCNT_W'(SETTLE_CYC);
                    end
                end
            end
            ST_RAMP: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (bus.enable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end else begin
                        // Target differs from code while ramping, so the
                        // step never wraps past 0 or full scale.
                        code_d = (target_q > code_q) ? code_q + CODE_W'(1)
                                                     : code_q - CODE_W'(1);
                        cnt_d  = bus.step_div;
                        if (code_d == target_q) begin
                            state_d = ST_SETTLE;
                            scnt_d  = SCNT_W'(SETTLE_CYC);
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (bus.enable) begin
                    if (scnt_q != '0) begin
                        scnt_d = scnt_q - SCNT_W'(1);
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        in_ready_d = (count_d != CNT_W'(DEPTH));
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            code_q     <= RESET_CODE;
            target_q   <= '0;
            cnt_q      <= '0;
            scnt_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            scnt_q     <= scnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (resetb && push) begin
            mem_q[wr_ptr_q] <= bus.in_code;
        end
    end

    assign bus.code_out = code_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.in_ready = in_ready_q;
    assign bus.fifo_cnt = count_q;
endmodule

// File: tb/tb_dac_code_sequencer.sv
module tb_dac_code_sequencer;
    localparam int CODE_W     = 4;
    localparam int DEPTH      = 4;
    localparam int DIV_W      = 8;
    localparam int SETTLE_CYC = 2;
    localparam int CNT_W      = 3;

    logic clk = 1'b0;
    logic resetb;
    always #5 clk = ~clk;

    dac_code_sequencer_if #(.CODE_W(CODE_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    dac_code_sequencer #(
        .CODE_W(CODE_W), .DEPTH(DEPTH), .DIV_W(DIV_W),
        .SETTLE_CYC(SETTLE_CYC), .RESET_CODE(4'hF)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    // Reference model: a job is described by its start code, target, step
    // period and the number of enabled cycles elapsed since the pop; the
    // expected code and done time follow directly from that arithmetic.
    int q[$];
    bit m_active = 0;
    int m_code = 15;
    int m_start, m_tgt, m_e, m_per;
    bit m_done = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int n, steps;
        bit do_pop, rdy;
        if (!resetb) begin
            q.delete();
            m_active = 0;
            m_code   = 15;
            m_done   = 0;
            return;
        end
        m_done = 0;
        rdy    = (q.size() < DEPTH);
        do_pop = !m_active && bus.enable && (q.size() > 0) && !bus.flush;
        if (m_active) begin
            if (bus.flush) begin
                m_active = 0;
            end else if (bus.enable) begin
                m_e++;
                n = (m_tgt >= m_start) ? m_tgt - m_start : m_start - m_tgt;
                steps = m_e / m_per;
                if (steps > n) steps = n;
                m_code = (m_tgt >= m_start) ? m_start + steps : m_start - steps;
                if (m_e == n * m_per + SETTLE_CYC + 1) begin
                    m_done   = 1;
                    m_active = 0;
                end
            end
        end
        if (do_pop) begin
            m_tgt    = q.pop_front();
            m_start  = m_code;
            m_e      = 0;
            m_per    = int'(bus.step_div) + 1;
            m_active = 1;
        end
        if (bus.flush) q.delete();
        else if (bus.in_valid && rdy) q.push_back(int'(bus.in_code));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("code_out", int'(bus.code_out), m_code);
        check("busy", int'(bus.busy), int'(m_active));
        check("done", int'(bus.done), int'(m_done));
        check("fifo_cnt", int'(bus.fifo_cnt), q.size());
        check("in_ready", int'(bus.in_ready), int'(q.size() < DEPTH));
        if (bus.done) done_seen++;
    endtask

    task automatic push_one(input int code);
        bus.in_valid = 1'b1;
        bus.in_code  = CODE_W'(code);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        resetb       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        bus.enable   = 1'b1;
        bus.flush    = 1'b0;
        bus.step_div = '0;
        run(2);
        resetb = 1'b1;
        run(2);

        // T2: full-scale ramp F -> 0, one step per cycle
        done_seen = 0;
        push_one(0);
        run(22);
        check("t2_done_count", done_seen, 1);
        check("t2_final_code", int'(bus.code_out), 0);

        // T3: divided ramp 5 -> 7
        push_one(5);
        run(12);
        bus.step_div = 8'd3;
        done_seen = 0;
        push_one(7);
        run(16);
        check("t3_done_count", done_seen, 1);
        check("t3_final_code", int'(bus.code_out), 7);

        // T4: target equals the current code
        bus.step_div = 8'd0;
        push_one(9);
        run(8);
        done_seen = 0;
        push_one(9);
        run(6);
        check("t4_done_count", done_seen, 1);
        check("t4_code", int'(bus.code_out), 9);

        // T5: fill the FIFO while frozen, overflow push is dropped
        bus.enable = 1'b0;
        for (int i = 0; i < 4; i++) push_one($urandom_range(0, 15));
        check("t5_ready_full", int'(bus.in_ready), 0);
        push_one(3);
        check("t5_cnt_full", int'(bus.fifo_cnt), 4);
        done_seen = 0;
        bus.enable = 1'b1;
        run(90);
        check("t5_done_count", done_seen, 4);

        // T6: freeze then flush mid-ramp
        bus.step_div = 8'd1;
        push_one((m_code < 8) ? 15 : 0);
        run(4);
        bus.enable = 1'b0;
        run(2);
        bus.enable = 1'b1;
        done_seen = 0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        run(6);
        check("t6_done_count", done_seen, 0);
        check("t6_busy", int'(bus.busy), 0);

        // T1: reset in the middle of a ramp
        bus.step_div = 8'd2;
        push_one((m_code < 8) ? 15 : 0);
        run(5);
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        check("t1_code", int'(bus.code_out), 15);
        check("t1_cnt", int'(bus.fifo_cnt), 0);
        run(2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            resetb       = ($urandom_range(0, 599) != 0);
            bus.in_valid = ($urandom_range(0, 2) == 0);
            bus.in_code  = CODE_W'($urandom_range(0, 15));
            bus.enable   = ($urandom_range(0, 7) != 0);
            bus.flush    = ($urandom_range(0, 63) == 0);
            if (!m_active && $urandom_range(0, 3) == 0)
                bus.step_div = DIV_W'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
